dmem_responder: RTL and testbench

//  Data-memory responder (slave end) for the pipeline core's Memory-stage load/store port.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Performs a byte-enabled word write or a word read, with configurable access latency.
//  - Returns a response over a valid/ready handshake, with an error flag.
//  - Sits between the core's Memory stage and on-chip data RAM.

---
 rtl/rv_mem_pkg.sv | 19 +
 rtl/dmem_bank.sv | 37 +++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the data-side and fetch-side memory
// responders.
//   mem_state_t : responder FSM state encoding
//   WORD_W      : data word width in bits
//   BE_W        : number of byte-enable lanes per word
//   MEM_ERR     : bit position of the error flag in a packed response status
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  localparam int WORD_W  = 32;
  localparam int BE_W    = 4;
  localparam int MEM_ERR = 0;

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: byte-enabled single-port synchronous RAM with registered read.
//   clk   : clock
//   en    : access enable; read register and write only update when set
//   we    : write enable (qualified by en and per-lane be)
//   be    : byte-lane enables, bit i selects wdata[8i+7:8i]
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (pre-write contents of the addressed word)
module dmem_bank
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core's Memory-stage load/store port.
// Accepts one request at a time, performs the RAM access LATENCY edges later
// (counting the accept edge), and presents the response until retired.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : request handshake
//   req_we, req_addr, req_wdata, req_be : request payload (store/load, byte addr, data, lanes)
//   rsp_valid/rsp_ready              : response handshake
//   rsp_rdata, rsp_err               : load data (0 for stores/errors), error flag
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  mem_state_t        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              accept, retire, commit;
  logic              cmd_we, cmd_err;
  logic [31:0]       cmd_addr;
  logic [WORD_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;
  logic              rsp_load_reg, rsp_err_reg;
  logic [WORD_W-1:0] bank_rdata;

  assign rsp_valid = (state_reg == ST_RESP);
  assign req_ready = ~rst & ((state_reg == ST_IDLE) | ((state_reg == ST_RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  assign retire    = rsp_valid & rsp_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        if (state_reg == ST_RESP && retire && !accept) begin
          state_next = ST_IDLE;
        end else if (accept) begin
          if (LATENCY == 1) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The RAM access happens on any edge that enters RESP from elsewhere, or
  // that re-enters RESP through a retire-plus-accept in a single-cycle build.
  assign commit = ~rst & (state_next == ST_RESP) & ((state_reg != ST_RESP) | accept);

  // With single-edge latency the access happens on the accept edge itself, so
  // the live request drives the RAM; otherwise the request is held in registers.
  generate
    if (LATENCY == 1) begin : g_direct
      assign cmd_we    = req_we;
      assign cmd_addr  = req_addr;
      assign cmd_wdata = req_wdata;
      assign cmd_be    = req_be;
    end else begin : g_latched
      logic              we_reg;
      logic [31:0]       addr_reg;
      logic [WORD_W-1:0] wdata_reg;
      logic [BE_W-1:0]   be_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          we_reg    <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          be_reg    <= '0;
        end else if (accept) begin
          we_reg    <= req_we;
          addr_reg  <= req_addr;
          wdata_reg <= req_wdata;
          be_reg    <= req_be;
        end
      end

      assign cmd_we    = we_reg;
      assign cmd_addr  = addr_reg;
      assign cmd_wdata = wdata_reg;
      assign cmd_be    = be_reg;
    end
  endgenerate

  assign cmd_err = (cmd_addr[1:0] != 2'b00) |
                   ({2'b00, cmd_addr[31:2]} >= 32'(DEPTH_WORDS));

  // The bank's read register only moves on commit, so it already holds the
  // load data stable through RESP; a flag selects it or forces zero.
  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk  (clk),
    .en   (commit & ~cmd_err),
    .we   (cmd_we),
    .be   (cmd_be),
    .idx  (cmd_addr[IDX_W+1:2]),
    .wdata(cmd_wdata),
    .rdata(bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_load_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else if (commit) begin
      rsp_load_reg <= ~cmd_we & ~cmd_err;
      rsp_err_reg  <= cmd_err;
    end
  end

  assign rsp_rdata = rsp_load_reg ? bank_rdata : '0;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int NI    = 2;   // instance 0: LATENCY=2, instance 1: LATENCY=1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int checks = 0;
  int errors = 0;
  logic [31:0] log1 [$];   // rdata of every retired response on instance 1

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUTs plus a per-instance reference model ----------------
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 2 : 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk      (clk),
      .rst      (rst[gi]),
      .req_valid(req_valid[gi]),
      .req_ready(req_ready[gi]),
      .req_we   (req_we[gi]),
      .req_addr (req_addr[gi]),
      .req_wdata(req_wdata[gi]),
      .req_be   (req_be[gi]),
      .rsp_valid(rsp_valid[gi]),
      .rsp_ready(rsp_ready[gi]),
      .rsp_rdata(rsp_rdata[gi]),
      .rsp_err  (rsp_err[gi])
    );

    typedef struct {
      int          due;     // cycle count at which the response must be visible
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          done;
      logic [31:0] rdata;
      logic        err;
    } ent_t;

    ent_t        q [$];
    logic [31:0] mm [int];
    int          cyc = 0;
    logic        rst_prev = 1'b1;

    always @(posedge clk) cyc++;

    // Model: a request decided at negedge c is accepted on the next edge and its
    // response is visible from cycle c+LAT onward; the memory effect lands then.
    always @(negedge clk) begin
      bit          ve, re;
      logic [31:0] w;
      int          idx;
      ve = (q.size() > 0) && (cyc >= q[0].due);
      if (ve && !q[0].done) begin
        idx = int'(q[0].addr[31:2]);
        q[0].err   = (q[0].addr[1:0] != 2'b00) || (idx >= DEPTH);
        q[0].rdata = 32'h0;
        if (!q[0].err) begin
          w = mm.exists(idx) ? mm[idx] : 32'h0;
          if (q[0].we) begin
            for (int b = 0; b < 4; b++)
              if (q[0].be[b]) w[8*b +: 8] = q[0].wdata[8*b +: 8];
            mm[idx] = w;
          end else begin
            q[0].rdata = w;
          end
        end
        q[0].done = 1'b1;
      end
      if (rst_prev) begin
        chk($sformatf("i%0d reset rsp_valid", gi), 32'(rsp_valid[gi]), 32'h0);
        chk($sformatf("i%0d reset rsp_rdata", gi), rsp_rdata[gi], 32'h0);
        chk($sformatf("i%0d reset rsp_err", gi), 32'(rsp_err[gi]), 32'h0);
      end else begin
        chk($sformatf("i%0d rsp_valid", gi), 32'(rsp_valid[gi]), 32'(ve));
        if (ve) begin
          chk($sformatf("i%0d rsp_rdata", gi), rsp_rdata[gi], q[0].rdata);
          chk($sformatf("i%0d rsp_err", gi), 32'(rsp_err[gi]), 32'(q[0].err));
        end
      end
      re = !rst[gi] && (q.size() == 0 || (ve && rsp_ready[gi]));
      chk($sformatf("i%0d req_ready", gi), 32'(req_ready[gi]), 32'(re));
      if (rst[gi]) begin
        q.delete();
      end else begin
        if (ve && rsp_ready[gi]) begin
          if (gi == 1) log1.push_back(q[0].rdata);
          void'(q.pop_front());
        end
        if (req_valid[gi] && re) begin
          ent_t e;
          e.due = cyc + LAT; e.we = req_we[gi]; e.addr = req_addr[gi];
          e.wdata = req_wdata[gi]; e.be = req_be[gi]; e.done = 1'b0;
          e.rdata = 32'h0; e.err = 1'b0;
          q.push_back(e);
        end
      end
      rst_prev = rst[gi];
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic wait_ready(input int k);
    int t = 0;
    @(negedge clk);
    while (!req_ready[k] && t < 50) begin @(negedge clk); t++; end
    if (!req_ready[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 on i%0d", k);
    end
  endtask

  task automatic wait_rsp(input int k, output logic [31:0] rd, output logic e);
    int t = 0;
    @(negedge clk);
    while (!(rsp_valid[k] && rsp_ready[k]) && t < 50) begin @(negedge clk); t++; end
    if (!(rsp_valid[k] && rsp_ready[k])) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 on i%0d", k);
    end
    rd = rsp_rdata[k];
    e  = rsp_err[k];
    @(posedge clk); #1;
  endtask

  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rd, output logic e);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_be[k] = be;
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_wdata[k] = ~wdata;   // later changes must be ignored
    req_addr[k]  = addr ^ 32'h4;
    wait_rsp(k, rd, e);
    $display("txn i%0d %s addr=0x%08h wdata=0x%08h be=%b -> rdata=0x%08h err=%0d",
             k, we ? "ST" : "LD", addr, wdata, be, rd, e);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd, held;
    logic        e;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready[0]), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // 1: full-word store then load
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
    chk("t1 store rdata", rd, 32'h0); chk("t1 store err", 32'(e), 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("t1 load rdata", rd, 32'hDEADBEEF); chk("t1 load err", 32'(e), 32'h0);

    // 2: single-lane store merges into existing word
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, e);
    chk("t2 merged", rd, 32'hDEADBEAA);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e);
    chk("t2 be0 err", 32'(e), 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("t2 be0 noop", rd, 32'hDEADBEAA);

    // 3: errors and the last legal word
    txn(0, 1'b1, 32'h0, 32'h11223344, 4'hF, rd, e);
    txn(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, e);
    chk("t3 misaligned err", 32'(e), 32'h1); chk("t3 misaligned rdata", rd, 32'h0);
    txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, rd, e);
    chk("t3 range err", 32'(e), 32'h1);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    chk("t3 word0 intact", rd, 32'h11223344);
    txn(0, 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, rd, e);
    chk("t3 last word err", 32'(e), 32'h0);
    txn(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, e);
    chk("t3 last word", rd, 32'hA5A5A5A5);

    // 4: backpressure, then retire and accept on the same edge
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
    wait_ready(0);
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0] = 32'h14; req_wdata[0] = 32'h55667788; req_be[0] = 4'hF;
    begin
      int t = 0;
      @(negedge clk);
      while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
    end
    held = rsp_rdata[0];
    chk("t4 held value", held, 32'hDEADBEAA);
    for (int c = 0; c < 5; c++) begin
      chk("t4 hold valid", 32'(rsp_valid[0]), 32'h1);
      chk("t4 hold rdata", rsp_rdata[0], held);
      chk("t4 hold req_ready", 32'(req_ready[0]), 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4 ready on retire", 32'(req_ready[0]), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, rd, e);
    chk("t4 second err", 32'(e), 32'h0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'hF, rd, e);
    chk("t4 second stored", rd, 32'h55667788);
    $display("txn i0 backpressure retire+accept done");

    // 5: reset while a store is pending
    txn(0, 1'b1, 32'h20, 32'h12345678, 4'hF, rd, e);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h0BADBAD0; req_be[0] = 4'hF;
    wait_ready(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5 no response", 32'(rsp_valid[0]), 32'h0);
    end
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, e);
    chk("t5 prior value", rd, 32'h12345678);

    // 6: single-cycle build, four back-to-back loads
    for (int i = 0; i < 4; i++)
      txn(1, 1'b1, 32'h40 + 32'(4*i), 32'h10000001 * (i + 1), 4'hF, rd, e);
    log1.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h40 + 32'(4*i);
      @(negedge clk);
      chk("t6 back2back ready", 32'(req_ready[1]), 32'h1);
      if (i > 0) chk("t6 no gap", 32'(rsp_valid[1]), 32'h1);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6 count", 32'(log1.size()), 32'd4);
    for (int i = 0; i < 4 && i < log1.size(); i++) begin
      chk("t6 order", log1[i], 32'h10000001 * (i + 1));
      $display("txn i1 LD addr=0x%08h -> rdata=0x%08h", 32'h40 + 32'(4*i), log1[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
